// File: rtl/led_pkg.sv
// Shared definitions for the WS2812 frame scheduler: FSM state encoding,
// pixel width, default chain geometry/timing, and the channel dimming helper.
package led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_LATCH = 2'd3
    } led_sched_state_t;

    localparam int BITS_PER_LED       = 24;
    localparam int DEF_N_LED          = 60;
    localparam int DEF_RESET_CYCLES   = 15000;  // 300 us at 50 MHz
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    // Dim one 8-bit colour channel: full scale at light=3, halving per step down.
    function automatic logic [7:0] scale_chan(input logic [7:0] chan, input logic [1:0] light);
        logic [1:0] shamt;
        shamt = 2'd3 - light;
        return chan >> shamt;
    endfunction

endpackage

// File: rtl/led_bright_scale.sv
// Per-channel brightness scaler for one 24-bit pixel. Only built and used when
// LED_BRIGHT_EN is defined; the default build streams raw pixels.
`ifdef LED_BRIGHT_EN
module led_bright_scale
    import led_pkg::*;
(
    input  logic [BITS_PER_LED-1:0] pix_i,
    input  logic [1:0]              light_i,
    output logic [BITS_PER_LED-1:0] pix_o
);

    // Shift each byte on its own so bits never bleed between colour channels.
    always_comb begin
        pix_o = '0;
        for (int c = 0; c < 3; c++) begin
            pix_o[8*c +: 8] = scale_chan(pix_i[8*c +: 8], light_i);
        end
    end

endmodule
`endif

// File: rtl/led_frame_sched.sv
// WS2812 frame scheduler: snapshots a frame on request, streams it pixel by
// pixel to the RZ encoder over tx_en/tx_done, holds the latch gap, then
// reports frame_done. Optional brightness scaling under macro LED_BRIGHT_EN.
module led_frame_sched
    import led_pkg::*;
#(
    parameter int N_LED          = DEF_N_LED,
    parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_req,
    input  logic [N_LED*BITS_PER_LED-1:0] rgb_reg,
    input  logic [1:0]                    light,
    input  logic                          tx_done,
    output logic                          frame_ack,
    output logic                          tx_en,
    output logic [BITS_PER_LED-1:0]       RGB,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          err_timeout
);

    localparam int IDX_W  = (N_LED > 1) ? $clog2(N_LED) : 1;
    localparam int TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LCNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_LED - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(RESET_CYCLES - 1);

    led_sched_state_t                       state_q, state_d;
    logic [IDX_W-1:0]                       idx_q, idx_d;
    logic [N_LED-1:0][BITS_PER_LED-1:0]     shadow_q, shadow_d;
    logic [BITS_PER_LED-1:0]                rgb_q, rgb_d;
    logic                                   tx_en_q, tx_en_d;
    logic                                   frame_ack_q, frame_ack_d;
    logic                                   busy_q, busy_d;
    logic                                   frame_done_q, frame_done_d;
    logic                                   err_q, err_d;
    logic [TCNT_W-1:0]                      tcnt_q, tcnt_d;
    logic [LCNT_W-1:0]                      lcnt_q, lcnt_d;

    logic [BITS_PER_LED-1:0]                pix_raw_s;
    logic [BITS_PER_LED-1:0]                pix_s;

    assign pix_raw_s = shadow_q[idx_q];

`ifdef LED_BRIGHT_EN
    led_bright_scale u_bright_scale (
        .pix_i   (pix_raw_s),
        .light_i (light),
        .pix_o   (pix_s)
    );
`else
    logic light_unused_s;
    assign light_unused_s = ^light;
    assign pix_s          = pix_raw_s;
`endif

    // State and output registers; reset mid-frame drops everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            shadow_q     <= '0;
            rgb_q        <= '0;
            tx_en_q      <= 1'b0;
            frame_ack_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            tcnt_q       <= '0;
            lcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            rgb_q        <= rgb_d;
            tx_en_q      <= tx_en_d;
            frame_ack_q  <= frame_ack_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            tcnt_q       <= tcnt_d;
            lcnt_q       <= lcnt_d;
        end
    end

    // Next-state logic: pulses default low, everything else holds.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        rgb_d        = rgb_q;
        tx_en_d      = 1'b0;
        frame_ack_d  = 1'b0;
        frame_done_d = 1'b0;
        busy_d       = busy_q;
        err_d        = err_q;
        tcnt_d       = tcnt_q;
        lcnt_d       = lcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_req) begin
                    shadow_d    = rgb_reg;
                    idx_d       = '0;
                    frame_ack_d = 1'b1;
                    busy_d      = 1'b1;
                    err_d       = 1'b0;
                    state_d     = ST_SEND;
                end else begin
                    busy_d      = 1'b0;
                end
            end
            ST_SEND: begin
                // RGB only changes here, so it is stable while the encoder runs.
                rgb_d   = pix_s;
                tx_en_d = 1'b1;
                tcnt_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done) begin
                    if (idx_q == IDX_LAST) begin
                        lcnt_d  = '0;
                        state_d = ST_LATCH;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_SEND;
                    end
                end else if (tcnt_q == TCNT_LAST) begin
                    err_d   = 1'b1;
                    lcnt_d  = '0;
                    state_d = ST_LATCH;
                end else begin
                    tcnt_d  = tcnt_q + TCNT_W'(1);
                end
            end
            ST_LATCH: begin
                // frame_done is raised in the final LATCH cycle, so a held request
                // sees exactly one IDLE cycle before it is accepted.
                if (frame_done_q) begin
                    state_d = ST_IDLE;
                end else if (lcnt_q == LCNT_LAST) begin
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                end else begin
                    lcnt_d = lcnt_q + LCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign frame_ack   = frame_ack_q;
    assign tx_en       = tx_en_q;
    assign RGB         = rgb_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_led_frame_sched.sv
// Directed bench for led_frame_sched with a 4-pixel chain, a 30-cycle encoder
// model, short latch gap and timeout. Frame vectors come from a table; reset,
// back-to-back, timeout and snapshot behaviour use hand-written sequences.
module tb_led_frame_sched;

    localparam int NL      = 4;
    localparam int RC      = 20;
    localparam int TC      = 64;
    localparam int ENC_LAT = 30;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              frame_req;
    logic [NL*24-1:0]  rgb_reg;
    logic [1:0]        light;
    logic              tx_done = 1'b0;
    logic              frame_ack, tx_en, busy, frame_done, err_timeout;
    logic [23:0]       RGB;

    led_frame_sched #(.N_LED(NL), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TC)) dut (
        .clk(clk), .rst_n(rst_n), .frame_req(frame_req), .rgb_reg(rgb_reg),
        .light(light), .tx_done(tx_done), .frame_ack(frame_ack), .tx_en(tx_en),
        .RGB(RGB), .busy(busy), .frame_done(frame_done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NL-1:0][23:0] pix;
        logic [1:0]          light;
        logic [NL-1:0][23:0] exp_bright;
    } vec_t;

    vec_t        vecs [4];
    int          n_vec = 0;
    int          n_bad = 0;

    int          tx_cyc[$];
    logic [23:0] tx_word[$];
    int          dn_cyc[$];
    int          ack_cyc[$];
    int          fd_cyc[$];
    int          err_cyc[$];
    bit          drop_pix2 = 1'b0;
    bit          enc_busy = 1'b0;
    int          enc_cnt = 0;
    int          enc_pix = 0;
    logic        err_prev = 1'b0;
    logic        err_at_ack = 1'b0;
    logic        busy_at_ack = 1'b0;
    logic        busy_at_fd = 1'b1;

    // Encoder model and event logger, sampled on the falling edge.
    always @(negedge clk) begin
        tx_done = 1'b0;
        if (!rst_n) begin
            enc_busy = 1'b0;
            enc_cnt  = 0;
            err_prev = 1'b0;
        end else begin
            if (enc_busy) begin
                enc_cnt++;
                if (enc_cnt == ENC_LAT) begin
                    enc_busy = 1'b0;
                    if (!(drop_pix2 && enc_pix == 2)) begin
                        tx_done = 1'b1;
                        dn_cyc.push_back(cyc);
                    end
                end
            end
            if (tx_en) begin
                enc_pix = tx_cyc.size();
                tx_cyc.push_back(cyc);
                tx_word.push_back(RGB);
                enc_busy = 1'b1;
                enc_cnt  = 0;
            end
            if (frame_ack) begin
                ack_cyc.push_back(cyc);
                err_at_ack  = err_timeout;
                busy_at_ack = busy;
            end
            if (frame_done) begin
                fd_cyc.push_back(cyc);
                busy_at_fd = busy;
            end
            if (err_timeout && !err_prev) err_cyc.push_back(cyc);
            err_prev = err_timeout;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < 0 || i >= q.size()) return -1;
        return q[i];
    endfunction

    task automatic clear_logs();
        tx_cyc.delete(); tx_word.delete(); dn_cyc.delete();
        ack_cyc.delete(); fd_cyc.delete(); err_cyc.delete();
    endtask

    task automatic wait_fd(input int n, input int budget);
        int k = 0;
        while (fd_cyc.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("frame_done_seen", fd_cyc.size(), n);
    endtask

    // One full frame: pulse request, corrupt rgb_reg after ack, check stream.
    task automatic run_frame(input vec_t v);
        int req_c;
        logic [23:0] exp_w;
        clear_logs();
        rgb_reg   = v.pix;
        light     = v.light;
        frame_req = 1'b1;
        req_c     = cyc;
        tick();
        frame_req = 1'b0;
        tick();
        rgb_reg   = {NL{24'hFFFFFF}};
        wait_fd(1, 1000);
        chk("ack_latency", qget(ack_cyc, 0), req_c + 1);
        chk("busy_at_ack", busy_at_ack, 1'b1);
        chk("err_clr_at_ack", err_at_ack, 1'b0);
        chk("tx_count", tx_cyc.size(), NL);
        chk("first_tx_en", qget(tx_cyc, 0), req_c + 2);
        for (int i = 0; i < NL; i++) begin
`ifdef LED_BRIGHT_EN
            exp_w = v.exp_bright[i];
`else
            exp_w = v.pix[i];
`endif
            chk($sformatf("word%0d", i), (i < tx_word.size()) ? tx_word[i] : 24'hDEAD00, exp_w);
            if (i > 0) chk($sformatf("tx_gap%0d", i), qget(tx_cyc, i), qget(dn_cyc, i - 1) + 2);
        end
        chk("frame_done_time", qget(fd_cyc, 0), qget(dn_cyc, NL - 1) + 1 + RC);
        chk("busy_at_done", busy_at_fd, 1'b0);
        chk("err_after_frame", err_timeout, 1'b0);
        tick();
        tick();
    endtask

    initial begin
        int k;
        vecs[0].pix = {24'hAABBCC, 24'h778899, 24'h445566, 24'h112233};
        vecs[0].light = 2'd3;
        vecs[0].exp_bright = {24'hAABBCC, 24'h778899, 24'h445566, 24'h112233};
        vecs[1].pix = {24'h0F0F0F, 24'hFFFFFF, 24'h000000, 24'hF08040};
        vecs[1].light = 2'd1;
        vecs[1].exp_bright = {24'h030303, 24'h3F3F3F, 24'h000000, 24'h3C2010};
        vecs[2].pix = {24'h0F0F0F, 24'hFFFFFF, 24'h000000, 24'hF08040};
        vecs[2].light = 2'd0;
        vecs[2].exp_bright = {24'h010101, 24'h1F1F1F, 24'h000000, 24'h1E1008};
        vecs[3].pix = {24'h0F0F0F, 24'hFFFFFF, 24'h000000, 24'hF08040};
        vecs[3].light = 2'd2;
        vecs[3].exp_bright = {24'h070707, 24'h7F7F7F, 24'h000000, 24'h784020};

        rst_n = 1'b0; frame_req = 1'b0; rgb_reg = '0; light = 2'd3;
        repeat (3) tick();
        chk("rst_RGB", RGB, 24'h0);
        chk("rst_tx_en", tx_en, 1'b0);
        chk("rst_frame_ack", frame_ack, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_err", err_timeout, 1'b0);
        rst_n = 1'b1;
        repeat (2) tick();

        for (int v = 0; v < 4; v++) run_frame(vecs[v]);

        // Request held high across a whole frame and beyond.
        clear_logs();
        rgb_reg = vecs[0].pix; light = 2'd3; frame_req = 1'b1;
        k = 0;
        while (ack_cyc.size() < 2 && k < 1000) begin tick(); k++; end
        frame_req = 1'b0;
        chk("b2b_second_ack", qget(ack_cyc, 1), qget(fd_cyc, 0) + 2);
        wait_fd(2, 1000);
        chk("b2b_tx_count", tx_cyc.size(), 2 * NL);
        chk("b2b_ack_count", ack_cyc.size(), 2);
        repeat (3) tick();

        // Encoder never finishes pixel 2.
        clear_logs();
        drop_pix2 = 1'b1;
        rgb_reg = vecs[0].pix; frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        wait_fd(1, 1000);
        drop_pix2 = 1'b0;
        chk("to_tx_count", tx_cyc.size(), 3);
        chk("to_err_time", qget(err_cyc, 0), qget(tx_cyc, 2) + TC);
        chk("to_done_time", qget(fd_cyc, 0), qget(tx_cyc, 2) + TC + RC);
        chk("to_err_sticky", err_timeout, 1'b1);
        repeat (3) tick();
        chk("to_err_still_sticky", err_timeout, 1'b1);
        run_frame(vecs[0]);

        // Asynchronous reset while waiting on pixel 1.
        clear_logs();
        rgb_reg = vecs[0].pix; frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        k = 0;
        while (tx_cyc.size() < 2 && k < 500) begin tick(); k++; end
        repeat (5) tick();
        chk("pre_rst_busy", busy, 1'b1);
        chk("pre_rst_RGB", RGB, 24'h445566);
        rst_n = 1'b0;
        #1;
        chk("arst_RGB", RGB, 24'h0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_tx_en", tx_en, 1'b0);
        chk("arst_frame_ack", frame_ack, 1'b0);
        chk("arst_frame_done", frame_done, 1'b0);
        chk("arst_err", err_timeout, 1'b0);
        repeat (3) tick();
        rst_n = 1'b1;
        clear_logs();
        repeat (RC + 40) tick();
        chk("arst_no_done", fd_cyc.size(), 0);
        chk("arst_no_tx", tx_cyc.size(), 0);
        run_frame(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
